shared_mem_responder: RTL and testbench

// - Memory-side end of the 3-CPU round-robin arbitration scheme: consumes the

---
 rtl/shared_mem_responder.sv | 136 +++++++++++++
 tb/tb_shared_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_responder
// Description : Memory-side responder for a 3-CPU round-robin arbiter.
//               Performs the granted CPU's read/write on an internal
//               single-port memory and returns CPU-tagged responses through
//               a LATENCY-deep read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_responder #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    grant,
  input  logic          req1,
  input  logic          req2,
  input  logic          req3,
  input  logic          we1,
  input  logic          we2,
  input  logic          we3,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic [DW-1:0] wdata3,
  output logic [DW-1:0] rdata,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic          rvalid3,
  output logic          wack1,
  output logic          wack2,
  output logic          wack3,
  output logic          busy
);

  localparam int C_DEPTH = 1 << AW;
  localparam int C_LAST  = LATENCY - 1;

  logic [DW-1:0] mem [C_DEPTH];

  logic          sel_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          wr_acc;
  logic          rd_acc;

  logic [LATENCY-1:0] vld_d, vld_q;
  logic [1:0]         tag_d [LATENCY];
  logic [1:0]         tag_q [LATENCY];
  logic [DW-1:0]      dat_d [LATENCY];
  logic [DW-1:0]      dat_q [LATENCY];
  logic [2:0]         wack_d, wack_q;

  // Route the granted CPU's request onto the single memory port.
  always_comb begin
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant)
      2'b01: begin sel_req = req1; sel_we = we1; sel_addr = addr1; sel_wdata = wdata1; end
      2'b10: begin sel_req = req2; sel_we = we2; sel_addr = addr2; sel_wdata = wdata2; end
      2'b11: begin sel_req = req3; sel_we = we3; sel_addr = addr3; sel_wdata = wdata3; end
      default: ;
    endcase
    // No accesses are accepted while reset is held, so memory never changes
    // without a matching write acknowledge.
    wr_acc = !reset && sel_req && sel_we;
    rd_acc = !reset && sel_req && !sel_we;
  end

  // Memory array: written on the accept edge, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[sel_addr] <= sel_wdata;
  end

  // Next state of the read pipeline and write acknowledges; data and tag
  // registers only load alongside a valid so rdata holds between responses.
  always_comb begin
    vld_d[0] = rd_acc;
    tag_d[0] = rd_acc ? grant : tag_q[0];
    dat_d[0] = rd_acc ? mem[sel_addr] : dat_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = vld_q[i-1] ? tag_q[i-1] : tag_q[i];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
    wack_d = 3'b000;
    if (wr_acc) begin
      case (grant)
        2'b01:   wack_d = 3'b001;
        2'b10:   wack_d = 3'b010;
        2'b11:   wack_d = 3'b100;
        default: wack_d = 3'b000;
      endcase
    end
  end

  // Pipeline and acknowledge registers; reset drops all in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      wack_q <= 3'b000;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= 2'b00;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      wack_q <= wack_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Responses come straight from the last pipeline stage.
  always_comb begin
    rdata   = dat_q[C_LAST];
    rvalid1 = vld_q[C_LAST] && (tag_q[C_LAST] == 2'b01);
    rvalid2 = vld_q[C_LAST] && (tag_q[C_LAST] == 2'b10);
    rvalid3 = vld_q[C_LAST] && (tag_q[C_LAST] == 2'b11);
    wack1   = wack_q[0];
    wack2   = wack_q[1];
    wack3   = wack_q[2];
    busy    = |vld_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_mem_responder
// Description : Directed self-checking bench; a LATENCY=2 and a LATENCY=1
//               instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  grant;
  logic        req1, req2, req3;
  logic        we1, we2, we3;
  logic [7:0]  addr1, addr2, addr3;
  logic [31:0] wdata1, wdata2, wdata3;

  logic [31:0] rdata_a, rdata_b;
  logic        rv1_a, rv2_a, rv3_a, wk1_a, wk2_a, wk3_a, busy_a;
  logic        rv1_b, rv2_b, rv3_b, wk1_b, wk2_b, wk3_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_mem_responder #(.AW(8), .DW(32), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .grant(grant),
    .req1(req1), .req2(req2), .req3(req3),
    .we1(we1), .we2(we2), .we3(we3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .rdata(rdata_a), .rvalid1(rv1_a), .rvalid2(rv2_a), .rvalid3(rv3_a),
    .wack1(wk1_a), .wack2(wk2_a), .wack3(wk3_a), .busy(busy_a)
  );

  shared_mem_responder #(.AW(8), .DW(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .grant(grant),
    .req1(req1), .req2(req2), .req3(req3),
    .we1(we1), .we2(we2), .we3(we3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .rdata(rdata_b), .rvalid1(rv1_b), .rvalid2(rv2_b), .rvalid3(rv3_b),
    .wack1(wk1_b), .wack2(wk2_b), .wack3(wk3_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    grant = 2'b00;
    req1 = 0; req2 = 0; req3 = 0;
    we1 = 0; we2 = 0; we3 = 0;
  endtask

  task automatic drive(input int cpu, input logic we, input logic [7:0] a, input logic [31:0] d);
    idle();
    case (cpu)
      1: begin grant = 2'b01; req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
      2: begin grant = 2'b10; req2 = 1; we2 = we; addr2 = a; wdata2 = d; end
      3: begin grant = 2'b11; req3 = 1; we3 = we; addr3 = a; wdata3 = d; end
      default: ;
    endcase
  endtask

  // LATENCY=2 instance: rvalid {3,2,1}, wack {3,2,1}, busy, rdata.
  task automatic chk_a(input string tag, input logic [2:0] rv, input logic [2:0] wk,
                       input logic bz, input logic [31:0] rd);
    chk({tag, "/a_rvalid"}, {29'd0, rv3_a, rv2_a, rv1_a}, {29'd0, rv});
    chk({tag, "/a_wack"},   {29'd0, wk3_a, wk2_a, wk1_a}, {29'd0, wk});
    chk({tag, "/a_busy"},   {31'd0, busy_a}, {31'd0, bz});
    chk({tag, "/a_rdata"},  rdata_a, rd);
  endtask

  // LATENCY=1 instance.
  task automatic chk_b(input string tag, input logic [2:0] rv, input logic [2:0] wk,
                       input logic bz, input logic [31:0] rd);
    chk({tag, "/b_rvalid"}, {29'd0, rv3_b, rv2_b, rv1_b}, {29'd0, rv});
    chk({tag, "/b_wack"},   {29'd0, wk3_b, wk2_b, wk1_b}, {29'd0, wk});
    chk({tag, "/b_busy"},   {31'd0, busy_b}, {31'd0, bz});
    chk({tag, "/b_rdata"},  rdata_b, rd);
  endtask

  initial begin
    addr1 = 0; addr2 = 0; addr3 = 0;
    wdata1 = 0; wdata2 = 0; wdata3 = 0;
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_a("reset", 3'b000, 3'b000, 1'b0, 32'h0);
    chk_b("reset", 3'b000, 3'b000, 1'b0, 32'h0);

    // Write then read back 0x10 on CPU1.
    drive(1, 1'b1, 8'h10, 32'hDEADBEEF);
    tick();
    chk_a("wr10", 3'b000, 3'b001, 1'b0, 32'h0);
    chk_b("wr10", 3'b000, 3'b001, 1'b0, 32'h0);
    drive(1, 1'b0, 8'h10, 32'h0);
    tick();
    chk_a("rd10_e0", 3'b000, 3'b000, 1'b1, 32'h0);
    chk_b("rd10_e0", 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
    idle();
    tick();
    chk_a("rd10_e1", 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
    chk_b("rd10_e1", 3'b000, 3'b000, 1'b0, 32'hDEADBEEF);
    tick();
    chk_a("rd10_hold", 3'b000, 3'b000, 1'b0, 32'hDEADBEEF);

    // Preload one word per CPU on consecutive edges.
    drive(1, 1'b1, 8'h11, 32'h11111111);
    tick();
    chk_a("wr11", 3'b000, 3'b001, 1'b0, 32'hDEADBEEF);
    drive(2, 1'b1, 8'h21, 32'h22222222);
    tick();
    chk_a("wr21", 3'b000, 3'b010, 1'b0, 32'hDEADBEEF);
    drive(3, 1'b1, 8'h31, 32'h33333333);
    tick();
    chk_a("wr31", 3'b000, 3'b100, 1'b0, 32'hDEADBEEF);

    // Back-to-back reads CPU1, CPU2, CPU3.
    drive(1, 1'b0, 8'h11, 32'h0);
    tick();
    chk_b("b2b_r1", 3'b001, 3'b000, 1'b1, 32'h11111111);
    drive(2, 1'b0, 8'h21, 32'h0);
    tick();
    chk_a("b2b_r1", 3'b001, 3'b000, 1'b1, 32'h11111111);
    chk_b("b2b_r2", 3'b010, 3'b000, 1'b1, 32'h22222222);
    drive(3, 1'b0, 8'h31, 32'h0);
    tick();
    chk_a("b2b_r2", 3'b010, 3'b000, 1'b1, 32'h22222222);
    chk_b("b2b_r3", 3'b100, 3'b000, 1'b1, 32'h33333333);
    idle();
    tick();
    chk_a("b2b_r3", 3'b100, 3'b000, 1'b1, 32'h33333333);
    tick();
    chk_a("b2b_done", 3'b000, 3'b000, 1'b0, 32'h33333333);

    // Granted CPU2 not requesting; CPU1/CPU3 try to write 0x10 and must be ignored.
    idle();
    grant = 2'b10;
    req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 32'h0BADF00D;
    req3 = 1; we3 = 1; addr3 = 8'h10; wdata3 = 32'h0BADF00D;
    tick();
    chk_a("noreq_e0", 3'b000, 3'b000, 1'b0, 32'h33333333);
    tick();
    chk_a("noreq_e1", 3'b000, 3'b000, 1'b0, 32'h33333333);
    chk_b("noreq_e1", 3'b000, 3'b000, 1'b0, 32'h33333333);
    drive(1, 1'b0, 8'h10, 32'h0);
    tick();
    idle();
    tick();
    chk_a("noreq_rb", 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
    tick();

    // Reset one cycle after a read accept drops the read.
    drive(2, 1'b0, 8'h21, 32'h0);
    tick();
    idle();
    reset = 1;
    tick();
    chk_a("rst_drop_e0", 3'b000, 3'b000, 1'b0, 32'h0);
    reset = 0;
    tick();
    chk_a("rst_drop_e1", 3'b000, 3'b000, 1'b0, 32'h0);
    drive(1, 1'b0, 8'h10, 32'h0);
    tick();
    idle();
    tick();
    chk_a("rst_mem_kept", 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
    tick();

    // CPU2 read at k-1, CPU3 write at k: rvalid2 and wack3 coincide.
    drive(2, 1'b0, 8'h21, 32'h0);
    tick();
    drive(3, 1'b1, 8'h32, 32'h3C3C3C3C);
    tick();
    chk_a("coincide", 3'b010, 3'b100, 1'b1, 32'h22222222);
    chk_b("coincide", 3'b000, 3'b100, 1'b0, 32'h22222222);
    drive(3, 1'b0, 8'h32, 32'h0);
    tick();
    chk_b("rd32", 3'b100, 3'b000, 1'b1, 32'h3C3C3C3C);
    idle();
    tick();
    chk_a("rd32", 3'b100, 3'b000, 1'b1, 32'h3C3C3C3C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
